// File: rtl/bmc_pkg.sv
// Shared constants, sample-cost function and metric typedef for the
// pipelined soft/hard branch-metric unit.
package bmc_pkg;

  function automatic int soft_max(input int w);
    return (1 << w) - 1;
  endfunction

  function automatic int bm_width(input int n, input int w);
    return w + $clog2(n);
  endfunction

  function automatic int num_cw(input int n);
    return 1 << n;
  endfunction

  // Cost of one sample against expected bit e.
  // Hard mode slices the sample down to its MSB first.
  function automatic int sample_cost(
    input int   s,
    input int   w,
    input logic e,
    input logic hard,
    input logic erase
  );
    if (erase)
      return 0;
    if (hard)
      return ((s >> (w - 1)) & 1) ^ int'(e);
    return e ? soft_max(w) - s : s;
  endfunction

  localparam int N_DEF      = 2;
  localparam int SOFT_W_DEF = 3;

  typedef logic [num_cw(N_DEF)*bm_width(N_DEF, SOFT_W_DEF)-1:0]
    bm_vec_t;

endpackage

// File: rtl/bmc_soft_pipe_argmin.sv
// Combinational lowest-index minimum over 2^N packed metrics.
// Ports: bm (packed metrics, k at [k*BM_W +: BM_W]), min_idx.
module bmc_argmin #(
  parameter int N    = 2,
  parameter int BM_W = 4
) (
  input  logic [(1<<N)*BM_W-1:0] bm,
  output logic [N-1:0]           min_idx
);

  logic [BM_W-1:0] best;

  // Strict less-than keeps the earliest index on ties.
  always_comb begin
    best    = bm[BM_W-1:0];
    min_idx = '0;
    for (int k = 1; k < (1 << N); k++) begin
      if (bm[k*BM_W +: BM_W] < best) begin
        best    = bm[k*BM_W +: BM_W];
        min_idx = N'(k);
      end
    end
  end

endmodule

// File: rtl/bmc_soft_pipe.sv
// Two-stage branch-metric unit: S1 sample costs, S2 sums + argmin.
// Ports: clk, rst_n (sync), in_* symbol handshake, out_* metric handshake.
module bmc_soft_pipe
  import bmc_pkg::*;
#(
  parameter int N      = 2,
  parameter int SOFT_W = 3,
  parameter int BM_W   = SOFT_W + $clog2(N),
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N*SOFT_W-1:0]      in_sym,
  input  logic [N-1:0]             in_erase,
  input  logic                     in_hard,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [(1<<N)*BM_W-1:0]   out_bm,
  output logic [N-1:0]             out_min_idx,
  output logic [CNT_W-1:0]         out_sym_cnt
);

  localparam int NUM_CW = num_cw(N);

  logic                s1_valid;
  logic [SOFT_W-1:0]   s1_c0 [N];
  logic [SOFT_W-1:0]   s1_c1 [N];
  logic [SOFT_W-1:0]   c0_d  [N];
  logic [SOFT_W-1:0]   c1_d  [N];
  logic                s2_adv;
  logic                s1_adv;
  logic [NUM_CW*BM_W-1:0] bm_sum;
  logic [N-1:0]        min_d;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = rst_n && s1_adv;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      c0_d[i] = SOFT_W'(sample_cost(
        int'(in_sym[i*SOFT_W +: SOFT_W]), SOFT_W,
        1'b0, in_hard, in_erase[i]));
      c1_d[i] = SOFT_W'(sample_cost(
        int'(in_sym[i*SOFT_W +: SOFT_W]), SOFT_W,
        1'b1, in_hard, in_erase[i]));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      for (int i = 0; i < N; i++) begin
        s1_c0[i] <= '0;
        s1_c1[i] <= '0;
      end
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_c0 <= c0_d;
        s1_c1 <= c1_d;
      end
    end
  end

  // Bit i of k picks which cost of sample i enters the sum.
  always_comb begin
    bm_sum = '0;
    for (int k = 0; k < NUM_CW; k++) begin
      for (int i = 0; i < N; i++) begin
        bm_sum[k*BM_W +: BM_W] = bm_sum[k*BM_W +: BM_W] +
          BM_W'(k[i] ? s1_c1[i] : s1_c0[i]);
      end
    end
  end

  bmc_argmin #(
    .N    (N),
    .BM_W (BM_W)
  ) u_argmin (
    .bm      (bm_sum),
    .min_idx (min_d)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_bm      <= '0;
      out_min_idx <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_bm      <= bm_sum;
        out_min_idx <= min_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      out_sym_cnt <= '0;
    else if (out_valid && out_ready)
      out_sym_cnt <= out_sym_cnt + 1'b1;
  end

endmodule

// File: tb/tb_bmc_soft_pipe.sv
// Scoreboard bench for bmc_soft_pipe (N=2, SOFT_W=3, CNT_W=4).
// Driver pushes expectations on input transfer; monitor pops on output.
module tb_bmc_soft_pipe;
  import bmc_pkg::*;

  localparam int N     = 2;
  localparam int SW    = 3;
  localparam int BMW   = 4;
  localparam int NCW   = 4;
  localparam int CNT_W = 4;

  typedef struct packed {
    bm_vec_t      bm;
    logic [N-1:0] idx;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [N*SW-1:0]  in_sym;
  logic [N-1:0]     in_erase;
  logic             in_hard;
  logic             out_valid;
  logic             out_ready;
  bm_vec_t          out_bm;
  logic [N-1:0]     out_min_idx;
  logic [CNT_W-1:0] out_sym_cnt;

  int   total = 0;
  int   passed = 0;
  int   accepted = 0;
  int   delivered = 0;
  exp_t q[$];
  exp_t cur_exp;

  always #5 clk = ~clk;

  bmc_soft_pipe #(
    .N      (N),
    .SOFT_W (SW),
    .CNT_W  (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sym      (in_sym),
    .in_erase    (in_erase),
    .in_hard     (in_hard),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_bm      (out_bm),
    .out_min_idx (out_min_idx),
    .out_sym_cnt (out_sym_cnt)
  );

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: direct sum of per-sample distances, then linear scan.
  function automatic exp_t model(input logic [N*SW-1:0] sym,
                                 input logic [N-1:0] er,
                                 input logic hard);
    exp_t r;
    int   m [NCW];
    int   best;
    r = '0;
    for (int k = 0; k < NCW; k++) begin
      m[k] = 0;
      for (int i = 0; i < N; i++) begin
        int s, want, d;
        s    = int'(sym[i*SW +: SW]);
        want = (k >> i) & 1;
        if (er[i]) d = 0;
        else if (hard) d = ((s >= 4 ? 1 : 0) != want) ? 1 : 0;
        else d = want ? 7 - s : s;
        m[k] += d;
      end
      r.bm[k*BMW +: BMW] = BMW'(m[k]);
    end
    best = m[0];
    for (int k = 1; k < NCW; k++)
      if (m[k] < best) begin
        best  = m[k];
        r.idx = N'(k);
      end
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("unexpected_output", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("bm", 32'(out_bm), 32'(e.bm));
        check("min_idx", 32'(out_min_idx), 32'(e.idx));
        check("sym_cnt", 32'(out_sym_cnt), 32'(delivered % 16));
      end
      delivered++;
    end
  end

  task automatic step();
    @(negedge clk);
    if (rst_n && in_valid && in_ready) begin
      q.push_back(cur_exp);
      accepted++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [N*SW-1:0] sym,
                      input logic [N-1:0] er,
                      input logic hard,
                      input exp_t e);
    in_sym   = sym;
    in_erase = er;
    in_hard  = hard;
    cur_exp  = e;
    in_valid = 1'b1;
  endtask

  task automatic send(input logic [N*SW-1:0] sym,
                      input logic [N-1:0] er,
                      input logic hard,
                      input exp_t e);
    int  a;
    bit  got;
    got = 0;
    load(sym, er, hard, e);
    for (int t = 0; t < 20 && !got; t++) begin
      a = accepted;
      step();
      if (accepted != a) got = 1;
    end
    if (!got) check("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic send_rand();
    logic [N*SW-1:0] s;
    logic [N-1:0]    er;
    logic            h;
    s  = N*SW'($urandom);
    er = ($urandom % 4 == 0) ? N'($urandom) : '0;
    h  = ($urandom % 3 == 0);
    send(s, er, h, model(s, er, h));
  endtask

  task automatic drain();
    for (int t = 0; t < 50 && q.size() > 0; t++) step();
    check("drain_empty", 32'(q.size()), 32'd0);
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    @(negedge clk);
    check("in_ready_in_reset", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    q.delete();
    delivered = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [N*SW-1:0] s;
    bm_vec_t         hold_bm;
    int              d0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sym    = '0;
    in_erase  = '0;
    in_hard   = 1'b0;
    out_ready = 1'b1;
    cur_exp   = '0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_bm", 32'(out_bm), 32'd0);
    check("rst_min_idx", 32'(out_min_idx), 32'd0);
    check("rst_cnt", 32'(out_sym_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed metrics with constant expectations.
    send({3'd0, 3'd7}, 2'b00, 1'b0, '{bm: 16'h7E07, idx: 2'd1});
    drain();
    check("cnt_after_first", 32'(out_sym_cnt), 32'd1);
    send({3'd0, 3'd7}, 2'b00, 1'b1, '{bm: 16'h1201, idx: 2'd1});
    send({3'd3, 3'd5}, 2'b10, 1'b0, '{bm: 16'h2525, idx: 2'd1});
    send({3'd3, 3'd5}, 2'b11, 1'b0, '{bm: 16'h0000, idx: 2'd0});
    send({3'd6, 3'd2}, 2'b11, 1'b1, '{bm: 16'h0000, idx: 2'd0});
    drain();

    // Stall: only two symbols fit, outputs hold.
    out_ready = 1'b0;
    accepted  = 0;
    s = 6'o16; load(s, 2'b00, 1'b0, model(s, 2'b00, 1'b0)); step();
    s = 6'o52; load(s, 2'b00, 1'b0, model(s, 2'b00, 1'b0)); step();
    s = 6'o34; load(s, 2'b01, 1'b0, model(s, 2'b01, 1'b0)); step();
    hold_bm = out_bm;
    for (int t = 0; t < 4; t++) step();
    check("stall_accepted", 32'(accepted), 32'd2);
    check("stall_in_ready", 32'(in_ready), 32'd0);
    check("stall_out_valid", 32'(out_valid), 32'd1);
    check("stall_bm_stable", 32'(out_bm), 32'(hold_bm));
    d0 = delivered;
    out_ready = 1'b1;
    step();
    s = 6'o61; load(s, 2'b00, 1'b1, model(s, 2'b00, 1'b1)); step();
    in_valid = 1'b0;
    step();
    step();
    check("release_4_in_4", 32'(delivered - d0), 32'd4);
    check("release_accepted", 32'(accepted), 32'd4);
    drain();

    // Reset with two symbols in flight.
    out_ready = 1'b0;
    send_rand();
    send_rand();
    reset_pulse();
    @(negedge clk);
    check("post_rst_valid", 32'(out_valid), 32'd0);
    check("post_rst_cnt", 32'(out_sym_cnt), 32'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    s = 6'o25;
    load(s, 2'b00, 1'b0, model(s, 2'b00, 1'b0));
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_cycle1", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("lat_cycle2", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;
    drain();

    // Counter wrap over 17 deliveries.
    reset_pulse();
    for (int j = 0; j < 17; j++) send_rand();
    drain();
    check("cnt_wrap_end", 32'(out_sym_cnt), 32'd1);

    // Random traffic with random backpressure.
    for (int t = 0; t < 400; t++) begin
      out_ready = ($urandom % 4) != 0;
      if ($urandom % 3 != 0) begin
        s = N*SW'($urandom);
        in_erase = ($urandom % 4 == 0) ? N'($urandom) : '0;
        load(s, in_erase, 1'($urandom), model(s, in_erase, in_hard));
      end else begin
        in_valid = 1'b0;
      end
      cur_exp = model(in_sym, in_erase, in_hard);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();
    check("final_cnt", 32'(out_sym_cnt), 32'(delivered % 16));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
